// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: memory-stage FSM states, writeback select
// codes, the default bus timeout and the writeback mux helper.
package pipeline_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } mem_state_e;

    // MemtoReg writeback select codes (2'b11 falls back to the ALU result)
    localparam logic [1:0] MTR_ALU = 2'b00;
    localparam logic [1:0] MTR_MEM = 2'b01;
    localparam logic [1:0] MTR_PC4 = 2'b10;

    // Cycles to wait for bus_ack before aborting; fits the 8-bit wait counter
    localparam int TIMEOUT_DEFAULT = 255;

    function automatic logic [31:0] wb_select(
        input logic [1:0]  memtoreg,
        input logic [31:0] alu_out,
        input logic [31:0] load_data,
        input logic [31:0] pc_plus_4
    );
        case (memtoreg)
            MTR_ALU: return alu_out;
            MTR_MEM: return load_data;
            MTR_PC4: return pc_plus_4;
            default: return alu_out;
        endcase
    endfunction

endpackage

// File: rtl/MEM_WB_Reg.sv
// MEM/WB pipeline register: takes the memory-stage result when the stage
// advances and inserts a bubble while the stage is stalled.
module MEM_WB_Reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic        i_reg_write,
    input  logic [4:0]  i_write_addr,
    input  logic [31:0] i_write_data,
    output logic        o_reg_write,
    output logic [4:0]  o_write_addr,
    output logic [31:0] o_write_data
);

    logic        r_reg_write;
    logic [4:0]  r_write_addr;
    logic [31:0] r_write_data;

    // Load the stage result on advance, otherwise clear to a bubble
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_reg_write  <= 1'b0;
            r_write_addr <= 5'd0;
            r_write_data <= 32'd0;
        end else if (i_load) begin
            r_reg_write  <= i_reg_write;
            r_write_addr <= i_write_addr;
            r_write_data <= i_write_data;
        end else begin
            r_reg_write  <= 1'b0;
            r_write_addr <= 5'd0;
            r_write_data <= 32'd0;
        end
    end

    assign o_reg_write  = r_reg_write;
    assign o_write_addr = r_write_addr;
    assign o_write_data = r_write_data;

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: issues one data-bus request per aligned load/store, stalls
// the front of the pipeline until the ack (or timeout), and feeds MEM/WB.
module mem_access_unit
    import pipeline_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemWrite,
    input  logic        MEM_RegWrite,
    input  logic [31:0] MEM_ALU_out,
    input  logic [31:0] MEM_WriteData,
    input  logic [31:0] MEM_PC_Plus_4,
    input  logic [4:0]  MEM_WriteAddr,
    input  logic [1:0]  MEM_MemtoReg,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        mem_stall,
    output logic        WB_RegWrite,
    output logic [4:0]  WB_WriteAddr,
    output logic [31:0] WB_WriteData,
    output logic        mem_misalign,
    output logic        bus_error
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    mem_state_e  r_state;
    logic        r_bus_req;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;
    logic [31:0] r_rdata;
    logic [7:0]  r_cnt;
    logic        r_misalign;
    logic        r_bus_error;

    logic        w_access;
    logic        w_aligned;
    logic        w_start;
    logic        w_misalign;
    logic [7:0]  w_cnt_next;
    logic        w_expire;
    logic        w_stall;
    logic        w_suppress;
    logic        w_wb_reg_write;
    logic [4:0]  w_wb_addr;
    logic [31:0] w_wb_data;

    assign w_access   = MEM_MemRead | MEM_MemWrite;
    assign w_aligned  = (MEM_ALU_out[1:0] == 2'b00);
    assign w_start    = (r_state == ST_IDLE) && w_access && w_aligned;
    assign w_misalign = (r_state == ST_IDLE) && w_access && !w_aligned;
    assign w_cnt_next = r_cnt + 8'd1;
    // Ack wins over expiry when both land on the last permitted wait cycle
    assign w_expire   = (r_state == ST_REQ) && !bus_ack && (w_cnt_next == TIMEOUT_CNT);

    // Held low during reset so the pipeline sees no stall while the unit is cleared
    assign w_stall    = reset && ((r_state == ST_REQ) || w_start);

    // A misaligned access (this cycle) or a timed-out access (in DONE) writes nothing back
    assign w_suppress     = w_misalign | r_bus_error;
    assign w_wb_reg_write = MEM_RegWrite & ~w_suppress;
    assign w_wb_addr      = w_suppress ? 5'd0 : MEM_WriteAddr;
    assign w_wb_data      = w_suppress ? 32'd0
                          : wb_select(MEM_MemtoReg, MEM_ALU_out, r_rdata, MEM_PC_Plus_4);

    // Bus FSM: latch the request in IDLE, hold it through REQ, settle in DONE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'd0;
            r_bus_wdata <= 32'd0;
            r_rdata     <= 32'd0;
            r_cnt       <= 8'd0;
            r_misalign  <= 1'b0;
            r_bus_error <= 1'b0;
        end else begin
            // NOTE: state is updated with <= so every register samples pre-edge values.
            r_misalign  <= w_misalign;
            r_bus_error <= w_expire;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state     <= ST_REQ;
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= MEM_MemWrite;
                        r_bus_addr  <= MEM_ALU_out;
                        r_bus_wdata <= MEM_WriteData;
                        r_cnt       <= 8'd0;
                    end
                end
                ST_REQ: begin
                    if (bus_ack) begin
                        r_rdata   <= bus_rdata;
                        r_state   <= ST_DONE;
                        r_bus_req <= 1'b0;
                    end else if (w_expire) begin
                        r_state   <= ST_DONE;
                        r_bus_req <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    MEM_WB_Reg u_mem_wb (
        .clk          (clk),
        .reset        (reset),
        .i_load       (!w_stall),
        .i_reg_write  (w_wb_reg_write),
        .i_write_addr (w_wb_addr),
        .i_write_data (w_wb_data),
        .o_reg_write  (WB_RegWrite),
        .o_write_addr (WB_WriteAddr),
        .o_write_data (WB_WriteData)
    );

    assign bus_req      = r_bus_req;
    assign bus_we       = r_bus_we;
    assign bus_addr     = r_bus_addr;
    assign bus_wdata    = r_bus_wdata;
    assign mem_stall    = w_stall;
    assign mem_misalign = r_misalign;
    assign bus_error    = r_bus_error;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: per-instruction expected waveforms built from
// the stage's timing rules, compared every cycle, plus literal spot checks.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk;
    logic        reset;
    logic        MEM_MemRead, MEM_MemWrite, MEM_RegWrite;
    logic [31:0] MEM_ALU_out, MEM_WriteData, MEM_PC_Plus_4;
    logic [4:0]  MEM_WriteAddr;
    logic [1:0]  MEM_MemtoReg;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        mem_stall;
    logic        WB_RegWrite;
    logic [4:0]  WB_WriteAddr;
    logic [31:0] WB_WriteData;
    logic        mem_misalign, bus_error;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk           (clk),
        .reset         (reset),
        .MEM_MemRead   (MEM_MemRead),
        .MEM_MemWrite  (MEM_MemWrite),
        .MEM_RegWrite  (MEM_RegWrite),
        .MEM_ALU_out   (MEM_ALU_out),
        .MEM_WriteData (MEM_WriteData),
        .MEM_PC_Plus_4 (MEM_PC_Plus_4),
        .MEM_WriteAddr (MEM_WriteAddr),
        .MEM_MemtoReg  (MEM_MemtoReg),
        .bus_req       (bus_req),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_rdata     (bus_rdata),
        .bus_ack       (bus_ack),
        .mem_stall     (mem_stall),
        .WB_RegWrite   (WB_RegWrite),
        .WB_WriteAddr  (WB_WriteAddr),
        .WB_WriteData  (WB_WriteData),
        .mem_misalign  (mem_misalign),
        .bus_error     (bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One instruction presented to the stage; ack_k = REQ cycle of the ack, 0 = never
    typedef struct {
        bit          rd, wr, rw;
        logic [31:0] alu, wdata, pc4;
        logic [4:0]  waddr;
        logic [1:0]  mtr;
        int          ack_k;
        logic [31:0] rdata;
        bit          ack_in_done;
    } vec_t;

    // Expected outputs of one cycle; wb_*/mis/berr are what must appear the cycle after
    typedef struct {
        bit          rst;
        bit          stall, req, we;
        logic [31:0] addr, wdata;
        bit          wb_rw;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        bit          mis, berr;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    exp_t        prev;
    int          n_vec = 0;
    int          n_err = 0;
    int          stall_seen = 0, req_seen = 0, berr_seen = 0, mis_seen = 0;
    int          s0, r0, b0, m0;
    logic [31:0] m_rdata;
    vec_t        v;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic exp_t blank(input bit stall, input bit req);
        exp_t e;
        e = '{default: 0};
        e.stall = stall;
        e.req   = req;
        return e;
    endfunction

    function automatic vec_t mk(input bit rd, input bit wr, input bit rw,
                                input logic [31:0] alu, input logic [31:0] wdata,
                                input logic [31:0] pc4, input logic [4:0] waddr,
                                input logic [1:0] mtr, input int ack_k,
                                input logic [31:0] rdata, input bit ack_in_done);
        vec_t x;
        x.rd = rd; x.wr = wr; x.rw = rw; x.alu = alu; x.wdata = wdata; x.pc4 = pc4;
        x.waddr = waddr; x.mtr = mtr; x.ack_k = ack_k; x.rdata = rdata;
        x.ack_in_done = ack_in_done;
        return x;
    endfunction

    // Writeback value by MemtoReg: 01 last captured bus data, 10 link, else ALU
    function automatic logic [31:0] wb_value(input vec_t x);
        if (x.mtr == 2'b01) return m_rdata;
        if (x.mtr == 2'b10) return x.pc4;
        return x.alu;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inputs(input vec_t x);
        MEM_MemRead   = x.rd;
        MEM_MemWrite  = x.wr;
        MEM_RegWrite  = x.rw;
        MEM_ALU_out   = x.alu;
        MEM_WriteData = x.wdata;
        MEM_PC_Plus_4 = x.pc4;
        MEM_WriteAddr = x.waddr;
        MEM_MemtoReg  = x.mtr;
    endtask

    task automatic set_nop();
        set_inputs(mk(0, 0, 0, 32'd0, 32'd0, 32'd0, 5'd0, 2'b00, 0, 32'd0, 0));
        bus_ack   = 1'b0;
        bus_rdata = 32'd0;
    endtask

    // Present one instruction for as many cycles as it occupies MEM and queue expectations
    task automatic run_vec(input vec_t x);
        exp_t e;
        bit   tmo;
        int   nreq;
        tick();
        set_inputs(x);
        bus_ack   = 1'b0;
        bus_rdata = $urandom;
        if (!(x.rd || x.wr)) begin
            e = blank(0, 0);
            e.wb_rw = x.rw; e.wb_addr = x.waddr; e.wb_data = wb_value(x);
            q.push_back(e);
        end else if (x.alu[1:0] != 2'b00) begin
            e = blank(0, 0);
            e.mis = 1;
            q.push_back(e);
        end else begin
            tmo  = !(x.ack_k >= 1 && x.ack_k <= TO);
            nreq = tmo ? TO : x.ack_k;
            q.push_back(blank(1, 0));
            for (int c = 1; c <= nreq; c++) begin
                tick();
                bus_ack   = (c == x.ack_k);
                bus_rdata = (c == x.ack_k) ? x.rdata : $urandom;
                e = blank(1, 1);
                e.we = x.wr; e.addr = x.alu; e.wdata = x.wdata;
                if (tmo && c == nreq) e.berr = 1;
                q.push_back(e);
            end
            if (!tmo) m_rdata = x.rdata;
            tick();
            bus_ack   = x.ack_in_done;
            bus_rdata = $urandom;
            e = blank(0, 0);
            if (!tmo) begin
                e.wb_rw = x.rw; e.wb_addr = x.waddr; e.wb_data = wb_value(x);
            end
            q.push_back(e);
        end
    endtask

    task automatic run_nop();
        run_vec(mk(0, 0, 0, 32'd0, 32'd0, 32'd0, 5'd0, 2'b00, 0, 32'd0, 0));
    endtask

    // Compare every queued cycle; WB and pulse outputs are checked one cycle late
    always @(negedge clk) begin
        if (q.size() > 0) begin
            cur = q.pop_front();
            if (mem_stall)    stall_seen++;
            if (bus_req)      req_seen++;
            if (bus_error)    berr_seen++;
            if (mem_misalign) mis_seen++;
            if (cur.rst) begin
                check("rst_stall", 32'(mem_stall), 32'd0);
                check("rst_bus_req", 32'(bus_req), 32'd0);
                check("rst_bus_we", 32'(bus_we), 32'd0);
                check("rst_bus_addr", bus_addr, 32'd0);
                check("rst_bus_wdata", bus_wdata, 32'd0);
                check("rst_wb_regwrite", 32'(WB_RegWrite), 32'd0);
                check("rst_wb_writeaddr", 32'(WB_WriteAddr), 32'd0);
                check("rst_wb_writedata", WB_WriteData, 32'd0);
                check("rst_mem_misalign", 32'(mem_misalign), 32'd0);
                check("rst_bus_error", 32'(bus_error), 32'd0);
            end else begin
                check("stall", 32'(mem_stall), 32'(cur.stall));
                check("bus_req", 32'(bus_req), 32'(cur.req));
                if (cur.req) begin
                    check("bus_we", 32'(bus_we), 32'(cur.we));
                    check("bus_addr", bus_addr, cur.addr);
                    check("bus_wdata", bus_wdata, cur.wdata);
                end
                check("wb_regwrite", 32'(WB_RegWrite), 32'(prev.wb_rw));
                check("wb_writeaddr", 32'(WB_WriteAddr), 32'(prev.wb_addr));
                check("wb_writedata", WB_WriteData, prev.wb_data);
                check("mem_misalign", 32'(mem_misalign), 32'(prev.mis));
                check("bus_error", 32'(bus_error), 32'(prev.berr));
            end
            prev = cur;
        end
    end

    initial begin
        exp_t e;
        reset   = 1'b0;
        m_rdata = 32'd0;
        prev    = blank(0, 0);
        set_nop();
        #1;
        check("por_bus_req", 32'(bus_req), 32'd0);
        check("por_wb_regwrite", 32'(WB_RegWrite), 32'd0);
        check("por_wb_writedata", WB_WriteData, 32'd0);
        check("por_bus_error", 32'(bus_error), 32'd0);
        e = blank(0, 0);
        e.rst = 1;
        tick(); q.push_back(e);
        tick(); q.push_back(e);
        tick(); reset = 1'b1; set_nop(); q.push_back(blank(0, 0));

        // ALU op and jal: no stall, result next cycle
        run_vec(mk(0, 0, 1, 32'h1111_0000, 32'd0, 32'h40, 5'd3, 2'b00, 0, 32'd0, 0));
        run_nop();
        @(negedge clk); #1;
        check("alu_wb_data", WB_WriteData, 32'h1111_0000);
        run_vec(mk(0, 0, 1, 32'h0000_0999, 32'd0, 32'h40, 5'd31, 2'b10, 0, 32'd0, 0));
        run_nop();
        @(negedge clk); #1;
        check("jal_wb_data", WB_WriteData, 32'h0000_0040);

        // Load 0x100, ack on 3rd REQ cycle; ack left high into DONE must be ignored
        s0 = stall_seen; r0 = req_seen;
        run_vec(mk(1, 0, 1, 32'h100, 32'd0, 32'h44, 5'd5, 2'b01, 3, 32'hDEAD_BEEF, 1));
        run_nop();
        @(negedge clk); #1;
        check("ld_stall_cycles", stall_seen - s0, 32'd4);
        check("ld_req_cycles", req_seen - r0, 32'd3);
        check("ld_wb_data", WB_WriteData, 32'hDEAD_BEEF);
        check("ld_wb_regwrite", 32'(WB_RegWrite), 32'd1);

        // Non-access with MemtoReg 01 sees the captured load data; 11 selects ALU
        run_vec(mk(0, 0, 1, 32'h0000_0777, 32'd0, 32'h48, 5'd6, 2'b01, 0, 32'd0, 0));
        run_vec(mk(0, 0, 1, 32'h0000_0888, 32'd0, 32'h4C, 5'd7, 2'b11, 0, 32'd0, 0));

        // Store 0x204, ack on 1st REQ cycle
        s0 = stall_seen; r0 = req_seen;
        run_vec(mk(0, 1, 0, 32'h204, 32'h1234_5678, 32'h50, 5'd0, 2'b00, 1, 32'hCAFE_0001, 0));
        run_nop();
        @(negedge clk); #1;
        check("st_stall_cycles", stall_seen - s0, 32'd2);
        check("st_req_cycles", req_seen - r0, 32'd1);
        check("st_wb_regwrite", 32'(WB_RegWrite), 32'd0);

        // Misaligned load 0x102 and misaligned store 0x203
        s0 = stall_seen; r0 = req_seen; m0 = mis_seen;
        run_vec(mk(1, 0, 1, 32'h102, 32'd0, 32'h54, 5'd8, 2'b01, 1, 32'h0, 0));
        run_nop();
        @(negedge clk); #1;
        check("mis_pulse", 32'(mem_misalign), 32'd1);
        check("mis_wb_regwrite", 32'(WB_RegWrite), 32'd0);
        check("mis_stall_cycles", stall_seen - s0, 32'd0);
        check("mis_req_cycles", req_seen - r0, 32'd0);
        run_vec(mk(0, 1, 0, 32'h203, 32'hAAAA_0000, 32'h58, 5'd0, 2'b00, 1, 32'h0, 0));
        run_nop();
        check("mis_pulse_count", mis_seen - m0, 32'd1);

        // Load 0x300 with no ack: abort after TO REQ cycles
        s0 = stall_seen; r0 = req_seen; b0 = berr_seen;
        run_vec(mk(1, 0, 1, 32'h300, 32'd0, 32'h5C, 5'd9, 2'b01, 0, 32'h0, 0));
        run_nop();
        @(negedge clk); #1;
        check("tmo_stall_cycles", stall_seen - s0, 32'd5);
        check("tmo_req_cycles", req_seen - r0, 32'd4);
        check("tmo_berr_cycles", berr_seen - b0, 32'd1);
        check("tmo_wb_regwrite", 32'(WB_RegWrite), 32'd0);

        // Ack on the last permitted REQ cycle completes normally
        run_vec(mk(1, 0, 1, 32'h304, 32'd0, 32'h60, 5'd10, 2'b01, TO, 32'h0A0B_0C0D, 0));
        // Read and write both set behave as a store
        run_vec(mk(1, 1, 0, 32'h400, 32'h55AA_55AA, 32'h64, 5'd0, 2'b00, 2, 32'h0, 0));
        run_nop();

        // Reset during REQ cycle 2 of load 0x500
        v = mk(1, 0, 1, 32'h500, 32'd0, 32'h68, 5'd11, 2'b01, 0, 32'h0, 0);
        tick(); set_inputs(v); bus_ack = 1'b0; q.push_back(blank(1, 0));
        tick();
        e = blank(1, 1);
        e.addr = 32'h500;
        q.push_back(e);
        tick(); reset = 1'b0; m_rdata = 32'd0;
        e = blank(0, 0);
        e.rst = 1;
        q.push_back(e);
        #1;
        check("rst_req_same_cycle", 32'(bus_req), 32'd0);
        check("rst_stall_same_cycle", 32'(mem_stall), 32'd0);
        tick(); reset = 1'b1; set_nop(); q.push_back(blank(0, 0));

        // Next load proceeds normally
        run_vec(mk(1, 0, 1, 32'h600, 32'd0, 32'h6C, 5'd12, 2'b01, 1, 32'h1357_9BDF, 0));
        run_nop();
        @(negedge clk); #1;
        check("post_rst_wb_data", WB_WriteData, 32'h1357_9BDF);
        run_nop();

        repeat (2) @(negedge clk);
        if (q.size() != 0) check("queue_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning max cycles waiting for bus_ack before aborting (8-bit counter).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-004 SHALL have ports MEM_MemRead, MEM_MemWrite, MEM_RegWrite  input  1 each  control bits from EX/MEM register.
REQ-005 SHALL have ports MEM_ALU_out, MEM_WriteData, MEM_PC_Plus_4  input  32 each  address/store data/link value from EX/MEM.
REQ-006 SHALL have ports MEM_WriteAddr  input  5 and MEM_MemtoReg  input  2  destination register and writeback select.
REQ-007 SHALL have ports bus_req, bus_we  output  1 each, bus_addr, bus_wdata  output  32 each  data-memory request side.
REQ-008 SHALL have ports bus_rdata  input  32 and bus_ack  input  1  data-memory response side.
REQ-009 SHALL have port mem_stall  output  1  freezes PC, IF/ID, ID/EX, EX/MEM when 1.
REQ-010 SHALL have ports WB_RegWrite  output  1, WB_WriteAddr  output  5, WB_WriteData  output  32  registered MEM/WB outputs.
REQ-011 SHALL have ports mem_misalign, bus_error  output  1 each  registered one-cycle error pulses.

Function
REQ-012 SHALL implement FSM states IDLE, REQ, DONE.
REQ-013 Access = MEM_MemRead | MEM_MemWrite; aligned = MEM_ALU_out[1:0]==2'b00; both read and write set SHALL be treated as a write.
REQ-014 IDLE with access & aligned: mem_stall=1 combinationally, next state REQ, latch addr/wdata/we into request registers.
REQ-015 IDLE with access & misaligned: no bus request, no stall, mem_misalign pulses next cycle, writeback suppressed (WB_RegWrite=0).
REQ-016 REQ: bus_req=1, bus_addr/bus_wdata/bus_we held stable from latched values, mem_stall=1 until leaving REQ.
REQ-017 REQ with bus_ack=1: capture bus_rdata, next state DONE; bus_req SHALL deassert in DONE.
REQ-018 REQ timeout counter counts from 0 per cycle without ack; at count==TIMEOUT without ack: next state DONE, bus_error pulses, writeback suppressed.
REQ-019 DONE: mem_stall=0, MEM/WB loads, next state IDLE; ack in DONE/IDLE SHALL be ignored.
REQ-020 Minimum latency for an access with ack after k REQ cycles: instruction occupies MEM for k+2 cycles (k>=1).
REQ-021 MEM/WB SHALL load each edge where mem_stall=0; when mem_stall=1 it SHALL load a bubble (WB_RegWrite=0, addr/data 0).
REQ-022 WB_WriteData SHALL select by MemtoReg: 00 ALU_out, 01 captured load data, 10 PC_Plus_4, 11 ALU_out.
REQ-023 Stores and non-access instructions SHALL pass WB_RegWrite=MEM_RegWrite unchanged (unless error suppression applies).

Reset
REQ-024 reset=0 SHALL immediately force state IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, counter=0, captured data=0.
REQ-025 reset=0 SHALL immediately force WB_RegWrite=0, WB_WriteAddr=0, WB_WriteData=0, mem_misalign=0, bus_error=0.
REQ-026 Reset mid-REQ SHALL abort the access without error pulse; mem_stall depends only on current state/inputs after reset.

Structure
REQ-027 FSM state encodings, MemtoReg encodings (00/01/10) and TIMEOUT default SHALL live in shared package pipeline_pkg.
REQ-028 MEM/WB register SHALL be sub-module MEM_WB_Reg, instantiated once; FSM and bus logic stay in mem_access_unit.

Verification
REQ-029 Load, addr 0x100, MemtoReg=01, ack 3rd REQ cycle, rdata 0xDEADBEEF -> stall 4 cycles, WB_WriteData=0xDEADBEEF, WB_RegWrite=1.
REQ-030 Store addr 0x204, wdata 0x12345678, ack 1st REQ cycle -> bus_we=1 with stable addr/data, stall 2 cycles, WB_RegWrite=0.
REQ-031 Load addr 0x102 -> no bus_req, mem_misalign pulse 1 cycle, WB_RegWrite=0, no stall.
REQ-032 Load, TIMEOUT=4, no ack -> bus_error pulse after 4 REQ cycles, return IDLE, WB_RegWrite=0.
REQ-033 reset=0 during REQ cycle 2 -> bus_req=0 same cycle, all outputs 0, next load proceeds normally.
REQ-034 ALU op MemtoReg=00 / jal MemtoReg=10, PC_Plus_4=0x40 -> no stall, WB_WriteData=ALU_out / 0x40 next cycle.
